// File: rtl/add_sched_if.sv
// ============================================================================
//  add_sched_if : bias stream from the sequencer to the add unit.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface add_sched_if #(
  parameter int QW = 4,
  parameter int XW = 32
);
  logic [QW-1:0][XW-1:0] bias_data;
  logic                  bias_valid;
  logic                  bias_ready;

  modport master (
    output bias_data,
    output bias_valid,
    input  bias_ready
  );

  modport slave (
    input  bias_data,
    input  bias_valid,
    output bias_ready
  );
endinterface

`default_nettype wire

// File: rtl/add_sched.sv
// ============================================================================
//  add_sched : per-layer bias sequencer; streams one latched bias vector per pixel
//  and counts add-unit output handshakes to detect layer completion.  Rev 1.0
// ============================================================================
`default_nettype none

module add_sched #(
  parameter int MAX_PIX = 4096,
  parameter int QW      = 4,
  parameter int XW      = 32,
  parameter int PW      = $clog2(MAX_PIX + 1)
) (
  input  wire logic                  clk,
  input  wire logic                  rstn,
  input  wire logic [QW-1:0][XW-1:0] cfg_bias_i,
  input  wire logic [PW-1:0]         cfg_npix_i,
  input  wire logic                  cfg_valid_i,
  output logic                       cfg_ready_o,
  input  wire logic                  start_i,
  input  wire logic                  flush_i,
  output logic                       busy_o,
  output logic                       done_o,
  add_sched_if.master                bias_if,
  input  wire logic                  sum_valid_i,
  input  wire logic                  sum_ready_i,
  output logic [PW-1:0]              pix_cnt_o,
  output logic                       err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [QW-1:0][XW-1:0] bias_q;
  logic [PW-1:0]         npix_q;
  logic                  loaded_q;
  logic [PW-1:0]         iss_cnt_q;
  logic [PW-1:0]         cmpl_cnt_q;
  logic [PW-1:0]         cmpl_cnt_d;
  logic                  done_q;
  logic                  err_q;

  logic w_cfg_fire;
  logic w_bias_valid;
  logic w_issue_fire;
  logic w_cmpl_fire;
  logic w_cmpl_ok;

  always_comb begin
    w_cfg_fire   = cfg_valid_i && (state_q == S_IDLE);
    w_bias_valid = (state_q == S_RUN) && (iss_cnt_q < npix_q);
    w_issue_fire = w_bias_valid && bias_if.bias_ready;
    w_cmpl_fire  = sum_valid_i && sum_ready_i;
    // A completion is only legal for a pixel whose bias has already gone out.
    w_cmpl_ok    = w_cmpl_fire && (state_q == S_RUN) && (cmpl_cnt_q < iss_cnt_q);
    cmpl_cnt_d   = cmpl_cnt_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      bias_q     <= '0;
      npix_q     <= '0;
      loaded_q   <= 1'b0;
      iss_cnt_q  <= '0;
      cmpl_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (w_cmpl_fire && !w_cmpl_ok) begin
        err_q <= 1'b1;
      end
      if (w_cfg_fire) begin
        bias_q   <= cfg_bias_i;
        npix_q   <= cfg_npix_i;
        loaded_q <= 1'b1;
      end
      if (flush_i) begin
        state_q    <= S_IDLE;
        iss_cnt_q  <= '0;
        cmpl_cnt_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            // start_i sees the config registers as they were before this edge
            if (start_i && loaded_q) begin
              iss_cnt_q  <= '0;
              cmpl_cnt_q <= '0;
              if (npix_q == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (w_issue_fire) begin
              iss_cnt_q <= iss_cnt_q + PW'(1);
            end
            if (w_cmpl_ok) begin
              cmpl_cnt_q <= cmpl_cnt_d;
              if (cmpl_cnt_d == npix_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign cfg_ready_o        = (state_q == S_IDLE);
  assign busy_o             = (state_q != S_IDLE);
  assign done_o             = done_q;
  assign err_o              = err_q;
  assign pix_cnt_o          = cmpl_cnt_q;
  assign bias_if.bias_data  = bias_q;
  assign bias_if.bias_valid = w_bias_valid;

endmodule

`default_nettype wire

// File: tb/tb_add_sched.sv
// Scoreboard bench for add_sched: expected bias beats and done pulses are queued at start,
// a negedge monitor pops and compares them as the DUT produces them.
`default_nettype none

module tb_add_sched;
  localparam int MAX_PIX = 4096;
  localparam int QW      = 4;
  localparam int XW      = 32;
  localparam int PW      = $clog2(MAX_PIX + 1);

  typedef logic [QW-1:0][XW-1:0] vec_t;
  typedef struct {
    bit   is_done;
    vec_t data;
    int   npix;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  vec_t          cfg_bias;
  logic [PW-1:0] cfg_npix;
  logic          cfg_valid, cfg_ready, start, flush, busy, done;
  logic          sum_valid, sum_ready, err;
  logic [PW-1:0] pix_cnt;

  add_sched_if #(.QW(QW), .XW(XW)) bif ();

  add_sched #(.MAX_PIX(MAX_PIX), .QW(QW), .XW(XW), .PW(PW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_bias_i  (cfg_bias),
    .cfg_npix_i  (cfg_npix),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .start_i     (start),
    .flush_i     (flush),
    .busy_o      (busy),
    .done_o      (done),
    .bias_if     (bif),
    .sum_valid_i (sum_valid),
    .sum_ready_i (sum_ready),
    .pix_cnt_o   (pix_cnt),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_sfire_cyc = -10;
  bit   prev_stall = 0;
  int   outstanding = 0;
  int   layer_cmpl = 0;
  bit   m_loaded = 0;
  vec_t m_bias;
  int   m_npix = 0;

  // Monitor: every bias handshake and done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rstn) begin
      if (prev_stall) begin
        total++;
        if (!bif.bias_valid) begin
          bad++;
          $display("FAIL bias_hold: bias_valid=%0b required 1 after stall", bif.bias_valid);
        end
      end
      prev_stall = bif.bias_valid && !bif.bias_ready && !flush;
      if (bif.bias_valid && bif.bias_ready) begin
        total++;
        if (q.size() == 0 || q[0].is_done) begin
          bad++;
          $display("FAIL bias_unexpected: got beat %0h, none expected", bif.bias_data);
        end else begin
          e = q.pop_front();
          if (bif.bias_data !== e.data) begin
            bad++;
            $display("FAIL bias_data: got %0h required %0h", bif.bias_data, e.data);
          end
        end
      end
      if (done) begin
        total++;
        if (q.size() == 0 || !q[0].is_done) begin
          bad++;
          $display("FAIL done_unexpected: done=1 with %0d beats still expected", q.size());
        end else begin
          e = q.pop_front();
          if (pix_cnt !== PW'(e.npix)) begin
            bad++;
            $display("FAIL done_pixcnt: got %0d required %0d", pix_cnt, e.npix);
          end
          if (e.npix != 0 && (cyc - last_sfire_cyc) != 1) begin
            bad++;
            $display("FAIL done_latency: got %0d cycles required 1", cyc - last_sfire_cyc);
          end
        end
      end
      if (sum_valid && sum_ready) last_sfire_cyc = cyc;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // One clock: drive at posedge+1, observe handshakes at negedge, update add-unit model.
  // mode 0: ready always 1; 1: bias_ready toggles 1010; 2: random.
  task automatic tick(input int mode, input int n);
    bit bf, sf;
    case (mode)
      0:       bif.bias_ready = 1'b1;
      1:       bif.bias_ready = (n % 2 == 0);
      default: bif.bias_ready = 1'($urandom_range(0, 1));
    endcase
    sum_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    sum_valid = (outstanding > 0) && ((mode != 2) || ($urandom_range(0, 2) != 0));
    @(negedge clk);
    bf = bif.bias_valid && bif.bias_ready;
    sf = sum_valid && sum_ready;
    @(posedge clk);
    #1;
    outstanding = outstanding + int'(bf) - int'(sf);
    layer_cmpl  = layer_cmpl + int'(sf);
  endtask

  task automatic do_cfg(input vec_t v, input int n);
    cfg_bias  = v;
    cfg_npix  = PW'(n);
    cfg_valid = 1'b1;
    chk("cfg_ready_idle", 128'(cfg_ready), 128'(1));
    tick(0, 0);
    cfg_valid = 1'b0;
    m_bias    = v;
    m_npix    = n;
    m_loaded  = 1;
  endtask

  task automatic do_start();
    exp_t e;
    start = 1'b1;
    if (m_loaded) begin
      for (int i = 0; i < m_npix; i++) begin
        e.is_done = 0; e.data = m_bias; e.npix = m_npix;
        q.push_back(e);
      end
      e.is_done = 1; e.data = m_bias; e.npix = m_npix;
      q.push_back(e);
      layer_cmpl = 0;
    end
    tick(0, 0);
    start = 1'b0;
  endtask

  task automatic drain(input int mode);
    int n = 0;
    while (q.size() > 0 && n < 2000) begin
      tick(mode, n);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL layer_timeout: %0d entries left required 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_layer(input vec_t v, input int n, input int mode);
    do_cfg(v, n);
    do_start();
    chk("busy_after_start", 128'(busy), 128'(1));
    chk("valid_latency", 128'(bif.bias_valid), 128'(n > 0));
    drain(mode);
    chk("idle_after_done", 128'(busy), 128'(0));
    chk("pixcnt_held", 128'(pix_cnt), 128'(n));
  endtask

  task automatic run_until_cmpl(input int k);
    int n = 0;
    while (layer_cmpl < k && n < 200) begin
      tick(0, n);
      n++;
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < QW; i++) v[i] = $urandom;
    return v;
  endfunction

  initial begin
    vec_t one;
    for (int i = 0; i < QW; i++) one[i] = 32'h3F80_0000;
    rstn = 1'b0; cfg_bias = '0; cfg_npix = '0; cfg_valid = 1'b0;
    start = 1'b0; flush = 1'b0; sum_valid = 1'b0; sum_ready = 1'b0;
    bif.bias_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_pixcnt", 128'(pix_cnt), 128'(0));
    chk("rst_valid", 128'(bif.bias_valid), 128'(0));
    chk("rst_data", 128'(bif.bias_data), 128'(0));
    rstn = 1'b1;

    // start before any config is ignored
    start = 1'b1; tick(0, 0); start = 1'b0;
    chk("start_unloaded", 128'(busy), 128'(0));

    run_layer(one, 4, 0);
    run_layer(rand_vec(), 3, 1);

    // zero-pixel layer: done one cycle after start, busy for one cycle only
    do_cfg(rand_vec(), 0);
    do_start();
    chk("npix0_done", 128'(done), 128'(1));
    chk("npix0_busy", 128'(busy), 128'(1));
    chk("npix0_valid", 128'(bif.bias_valid), 128'(0));
    tick(0, 0);
    chk("npix0_busy_end", 128'(busy), 128'(0));
    chk("npix0_done_end", 128'(done), 128'(0));

    for (int l = 0; l < 6; l++) run_layer(rand_vec(), $urandom_range(1, 12), 2);

    // reuse of the loaded config without a new cfg handshake
    do_start();
    drain(2);
    chk("reuse_pixcnt", 128'(pix_cnt), 128'(m_npix));

    // flush after 2 of 5 pixels, then restart the same config
    do_cfg(rand_vec(), 5);
    do_start();
    run_until_cmpl(2);
    flush = 1'b1; tick(0, 0); flush = 1'b0;
    q.delete(); outstanding = 0;
    chk("flush_busy", 128'(busy), 128'(0));
    chk("flush_pixcnt", 128'(pix_cnt), 128'(0));
    chk("flush_done", 128'(done), 128'(0));
    tick(0, 0);
    chk("flush_no_done", 128'(done), 128'(0));
    do_start();
    drain(0);
    chk("restart_pixcnt", 128'(pix_cnt), 128'(5));
    chk("err_clean", 128'(err), 128'(0));

    // stray completion in IDLE is a sticky protocol error
    sum_valid = 1'b1; sum_ready = 1'b1;
    @(posedge clk); #1;
    sum_valid = 1'b0;
    chk("err_set", 128'(err), 128'(1));
    run_layer(rand_vec(), 3, 2);
    chk("err_sticky", 128'(err), 128'(1));

    // reset in the middle of a layer abandons it and drops the config
    do_cfg(rand_vec(), 6);
    do_start();
    run_until_cmpl(2);
    rstn = 1'b0; tick(0, 0); rstn = 1'b1;
    q.delete(); outstanding = 0; m_loaded = 0;
    chk("rst2_busy", 128'(busy), 128'(0));
    chk("rst2_err", 128'(err), 128'(0));
    chk("rst2_pixcnt", 128'(pix_cnt), 128'(0));
    chk("rst2_valid", 128'(bif.bias_valid), 128'(0));
    chk("rst2_data", 128'(bif.bias_data), 128'(0));
    start = 1'b1; tick(0, 0); start = 1'b0;
    chk("rst2_start_ign", 128'(busy), 128'(0));
    // cfg and start together while unloaded: start sees the old (empty) state
    cfg_bias = rand_vec(); cfg_npix = PW'(2); cfg_valid = 1'b1; start = 1'b1;
    tick(0, 0);
    cfg_valid = 1'b0; start = 1'b0;
    m_bias = cfg_bias; m_npix = 2; m_loaded = 1;
    chk("same_cycle_ign", 128'(busy), 128'(0));
    do_start();
    drain(2);
    chk("final_pixcnt", 128'(pix_cnt), 128'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
